ex_mem_stage: RTL and testbench

- EX/MEM pipeline boundary of the pipelined RISC-V core. It sits directly downstream of the 32-bit ALU.
- Registers the ALU result and flags, plus store data and control, for the memory stage.
- Resolves conditional branches from the ALU flags, where the ALU has computed rs1 − rs2.
- Issues a one-cycle redirect pulse and squashes wrong-path instructions arriving in the shadow cycles.

---
 rtl/ex_mem_stage_pkg.sv | 19 +
 rtl/ex_mem_stage_if.sv | 49 ++++
 rtl/ex_mem_stage_branch_cond.sv | 28 ++
 rtl/ex_mem_stage.sv | 114 +++++++++++
 tb/tb_ex_mem_stage.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX/MEM pipeline boundary: datapath widths and
// branch-type encodings used by the stage and its branch resolver.
package ex_mem_stage_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_LT   = 3'd3,
        BR_GE   = 3'd4,
        BR_LTU  = 3'd5,
        BR_GEU  = 3'd6,
        BR_JAL  = 3'd7
    } br_type_e;

endpackage

// File: rtl/ex_mem_stage_if.sv
// Bundle of the EX-side inputs and MEM-side outputs of the EX/MEM stage.
// The master drives the EX side and observes MEM; the slave is the stage itself.
interface ex_mem_stage_if;
    import ex_mem_stage_pkg::*;

    logic              in_valid;
    logic [XLEN-1:0]   alu_result;
    logic              alu_carry;
    logic              alu_zero;
    logic              alu_negative;
    logic              alu_overflow;
    logic [XLEN-1:0]   store_data;
    logic [REG_W-1:0]  rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [2:0]        br_type;
    logic [XLEN-1:0]   br_target;
    logic              stall;
    logic              flush;

    logic              out_valid;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [REG_W-1:0]  mem_rd;
    logic              mem_reg_write;
    logic              mem_read_o;
    logic              mem_write_o;
    logic              redirect;
    logic [XLEN-1:0]   redirect_pc;
    logic              fwd_valid;

    modport master (
        output in_valid, alu_result, alu_carry, alu_zero, alu_negative, alu_overflow,
               store_data, rd, reg_write, mem_read, mem_write, br_type, br_target,
               stall, flush,
        input  out_valid, mem_addr, mem_wdata, mem_rd, mem_reg_write, mem_read_o,
               mem_write_o, redirect, redirect_pc, fwd_valid
    );

    modport slave (
        input  in_valid, alu_result, alu_carry, alu_zero, alu_negative, alu_overflow,
               store_data, rd, reg_write, mem_read, mem_write, br_type, br_target,
               stall, flush,
        output out_valid, mem_addr, mem_wdata, mem_rd, mem_reg_write, mem_read_o,
               mem_write_o, redirect, redirect_pc, fwd_valid
    );

endinterface

// File: rtl/ex_mem_stage_branch_cond.sv
// Branch resolver: decides taken from the ALU flags of rs1 - rs2.
// carry_i is already the borrow, so it directly means rs1 < rs2 unsigned.
module ex_mem_stage_branch_cond
    import ex_mem_stage_pkg::*;
(
    input  br_type_e br_type_i,
    input  logic     zero_i,
    input  logic     negative_i,
    input  logic     overflow_i,
    input  logic     carry_i,
    output logic     taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case (br_type_i)
            BR_EQ:   taken_o = zero_i;
            BR_NE:   taken_o = !zero_i;
            BR_LT:   taken_o = negative_i ^ overflow_i;
            BR_GE:   taken_o = !(negative_i ^ overflow_i);
            BR_LTU:  taken_o = carry_i;
            BR_GEU:  taken_o = !carry_i;
            BR_JAL:  taken_o = 1'b1;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: latches ALU result, store data and control for MEM,
// resolves branches and squashes wrong-path instructions in the redirect shadow.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int SHADOW = 2
)
(
    input  logic           clk,
    input  logic           rst_n,
    ex_mem_stage_if.slave  pipe_io
);

    localparam logic [2:0] SHADOW_INIT = 3'(SHADOW);

    logic              valid_q,  valid_d;
    logic [XLEN-1:0]   addr_q,   addr_d;
    logic [XLEN-1:0]   wdata_q,  wdata_d;
    logic [REG_W-1:0]  rd_q,     rd_d;
    logic              rw_q,     rw_d;
    logic              mr_q,     mr_d;
    logic              mw_q,     mw_d;
    logic              redir_q,  redir_d;
    logic [XLEN-1:0]   rpc_q,    rpc_d;
    logic [2:0]        shadow_q, shadow_d;

    logic taken;
    logic effValid;
    logic [2:0] shadowDec;

    ex_mem_stage_branch_cond u_branch_cond (
        .br_type_i  (br_type_e'(pipe_io.br_type)),
        .zero_i     (pipe_io.alu_zero),
        .negative_i (pipe_io.alu_negative),
        .overflow_i (pipe_io.alu_overflow),
        .carry_i    (pipe_io.alu_carry),
        .taken_o    (taken)
    );

    assign effValid  = pipe_io.in_valid && !pipe_io.flush && (shadow_q == 3'd0);
    assign shadowDec = (shadow_q != 3'd0) ? shadow_q - 3'd1 : 3'd0;

    // Stall freezes everything except the redirect pulse, which must not repeat.
    always_comb begin
        valid_d  = valid_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        rw_d     = rw_q;
        mr_d     = mr_q;
        mw_d     = mw_q;
        redir_d  = 1'b0;
        rpc_d    = rpc_q;
        shadow_d = shadow_q;
        if (pipe_io.stall) begin
            shadow_d = shadow_q;
        end else if (pipe_io.flush) begin
            valid_d  = 1'b0;
            rw_d     = 1'b0;
            mr_d     = 1'b0;
            mw_d     = 1'b0;
            shadow_d = shadowDec;
        end else begin
            valid_d  = effValid;
            addr_d   = pipe_io.alu_result;
            wdata_d  = pipe_io.store_data;
            rd_d     = pipe_io.rd;
            rw_d     = pipe_io.reg_write && effValid;
            mr_d     = pipe_io.mem_read  && effValid;
            mw_d     = pipe_io.mem_write && effValid;
            redir_d  = effValid && taken;
            rpc_d    = pipe_io.br_target;
            shadow_d = (effValid && taken) ? SHADOW_INIT : shadowDec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
            rw_q     <= 1'b0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
            redir_q  <= 1'b0;
            rpc_q    <= '0;
            shadow_q <= '0;
        end else begin
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            rw_q     <= rw_d;
            mr_q     <= mr_d;
            mw_q     <= mw_d;
            redir_q  <= redir_d;
            rpc_q    <= rpc_d;
            shadow_q <= shadow_d;
        end
    end

    assign pipe_io.out_valid     = valid_q;
    assign pipe_io.mem_addr      = addr_q;
    assign pipe_io.mem_wdata     = wdata_q;
    assign pipe_io.mem_rd        = rd_q;
    assign pipe_io.mem_reg_write = rw_q;
    assign pipe_io.mem_read_o    = mr_q;
    assign pipe_io.mem_write_o   = mw_q;
    assign pipe_io.redirect      = redir_q;
    assign pipe_io.redirect_pc   = rpc_q;
    assign pipe_io.fwd_valid     = valid_q && rw_q && (rd_q != '0);

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: a reference model predicts every MEM-side
// output per cycle, pushes it to a queue, and the queue is drained after each edge.
module tb_ex_mem_stage;
    import ex_mem_stage_pkg::*;

    localparam int SHADOW = 2;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        redir;
        logic [31:0] rpc;
        logic        fwd;
    } exp_t;

    typedef struct {
        logic        valid;
        logic [31:0] res;
        logic        c, z, n, v;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw, mr, mw;
        logic [2:0]  bt;
        logic [31:0] tgt;
        logic        stall, flush;
    } stim_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    ex_mem_stage_if bus ();

    ex_mem_stage #(.SHADOW(SHADOW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pipe_io (bus)
    );

    exp_t  cur;
    int    shadowModel;
    exp_t  sbQueue[$];
    int    checks;
    int    errors;
    stim_t s;

    function automatic stim_t idleStim();
        stim_t t;
        t.valid = 1'b0; t.res = '0; t.c = 1'b0; t.z = 1'b0; t.n = 1'b0; t.v = 1'b0;
        t.sd = '0; t.rd = '0; t.rw = 1'b0; t.mr = 1'b0; t.mw = 1'b0;
        t.bt = 3'd0; t.tgt = '0; t.stall = 1'b0; t.flush = 1'b0;
        return t;
    endfunction

    function automatic logic modelTaken(input stim_t t);
        case (t.bt)
            3'd1:    return t.z;
            3'd2:    return !t.z;
            3'd3:    return t.n ^ t.v;
            3'd4:    return !(t.n ^ t.v);
            3'd5:    return t.c;
            3'd6:    return !t.c;
            3'd7:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic driveInputs(input stim_t t);
        bus.in_valid     = t.valid;
        bus.alu_result   = t.res;
        bus.alu_carry    = t.c;
        bus.alu_zero     = t.z;
        bus.alu_negative = t.n;
        bus.alu_overflow = t.v;
        bus.store_data   = t.sd;
        bus.rd           = t.rd;
        bus.reg_write    = t.rw;
        bus.mem_read     = t.mr;
        bus.mem_write    = t.mw;
        bus.br_type      = t.bt;
        bus.br_target    = t.tgt;
        bus.stall        = t.stall;
        bus.flush        = t.flush;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_out_valid"},   32'(bus.out_valid),     32'd0);
        checkOutput({tag, "_mem_addr"},    bus.mem_addr,           32'd0);
        checkOutput({tag, "_mem_wdata"},   bus.mem_wdata,          32'd0);
        checkOutput({tag, "_mem_rd"},      32'(bus.mem_rd),        32'd0);
        checkOutput({tag, "_reg_write"},   32'(bus.mem_reg_write), 32'd0);
        checkOutput({tag, "_mem_read"},    32'(bus.mem_read_o),    32'd0);
        checkOutput({tag, "_mem_write"},   32'(bus.mem_write_o),   32'd0);
        checkOutput({tag, "_redirect"},    32'(bus.redirect),      32'd0);
        checkOutput({tag, "_redirect_pc"}, bus.redirect_pc,        32'd0);
        checkOutput({tag, "_fwd_valid"},   32'(bus.fwd_valid),     32'd0);
    endtask

    task automatic compareScoreboard();
        exp_t e;
        if (sbQueue.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            e = sbQueue.pop_front();
            checkOutput("out_valid",   32'(bus.out_valid),     32'(e.valid));
            checkOutput("mem_addr",    bus.mem_addr,           e.addr);
            checkOutput("mem_wdata",   bus.mem_wdata,          e.wdata);
            checkOutput("mem_rd",      32'(bus.mem_rd),        32'(e.rd));
            checkOutput("reg_write",   32'(bus.mem_reg_write), 32'(e.rw));
            checkOutput("mem_read",    32'(bus.mem_read_o),    32'(e.mr));
            checkOutput("mem_write",   32'(bus.mem_write_o),   32'(e.mw));
            checkOutput("redirect",    32'(bus.redirect),      32'(e.redir));
            checkOutput("redirect_pc", bus.redirect_pc,        e.rpc);
            checkOutput("fwd_valid",   32'(bus.fwd_valid),     32'(e.fwd));
        end
    endtask

    // Called at a falling edge; returns at the next falling edge after checking.
    task automatic applyStimulus(input stim_t t);
        exp_t nxt;
        logic ev;
        logic tk;
        driveInputs(t);
        tk  = modelTaken(t);
        ev  = t.valid && !t.flush && (shadowModel == 0);
        nxt = cur;
        nxt.redir = 1'b0;
        if (t.stall) begin
            nxt.redir = 1'b0;
        end else if (t.flush) begin
            nxt.valid = 1'b0;
            nxt.rw = 1'b0;
            nxt.mr = 1'b0;
            nxt.mw = 1'b0;
            if (shadowModel > 0) shadowModel--;
        end else begin
            nxt.valid = ev;
            nxt.addr  = t.res;
            nxt.wdata = t.sd;
            nxt.rd    = t.rd;
            nxt.rw    = t.rw && ev;
            nxt.mr    = t.mr && ev;
            nxt.mw    = t.mw && ev;
            nxt.redir = ev && tk;
            nxt.rpc   = t.tgt;
            if (ev && tk) shadowModel = SHADOW;
            else if (shadowModel > 0) shadowModel--;
        end
        nxt.fwd = nxt.valid && nxt.rw && (nxt.rd != 5'd0);
        cur = nxt;
        sbQueue.push_back(nxt);
        @(posedge clk);
        #1;
        compareScoreboard();
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cur = '0;
        shadowModel = 0;
        driveInputs(idleStim());
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkResetState("reset");
        rst_n = 1'b1;

        s = idleStim();
        s.valid = 1'b1; s.res = 32'h0000_1234; s.sd = 32'hDEAD_BEEF; s.rd = 5'd5; s.mw = 1'b1;
        applyStimulus(s);

        // 1 - 0xFFFFFFFF: borrow set, signed result positive, so BLTU taken and BLT not.
        s = idleStim();
        s.valid = 1'b1; s.res = 32'h0000_0002; s.c = 1'b1; s.bt = 3'd5; s.tgt = 32'h0000_0200;
        applyStimulus(s);
        repeat (2) applyStimulus(idleStim());
        s.bt = 3'd3; s.tgt = 32'h0000_0240;
        applyStimulus(s);

        s = idleStim();
        s.valid = 1'b1; s.z = 1'b1; s.bt = 3'd1; s.tgt = 32'h0000_0080;
        applyStimulus(s);
        for (int i = 1; i <= 3; i++) begin
            s = idleStim();
            s.valid = 1'b1; s.mw = 1'b1; s.res = 32'h100 + 32'(i); s.sd = 32'(i); s.rd = 5'(i);
            applyStimulus(s);
        end

        s = idleStim();
        s.valid = 1'b1; s.bt = 3'd7; s.tgt = 32'h0000_0300; s.stall = 1'b1;
        repeat (3) applyStimulus(s);
        s.stall = 1'b0;
        applyStimulus(s);
        s = idleStim();
        s.valid = 1'b1; s.mw = 1'b1; s.res = 32'h44; s.stall = 1'b1; s.flush = 1'b1;
        applyStimulus(s);
        s.stall = 1'b0;
        applyStimulus(s);
        repeat (2) applyStimulus(idleStim());

        s = idleStim();
        s.valid = 1'b1; s.bt = 3'd7; s.tgt = 32'h0000_0500; s.flush = 1'b1;
        applyStimulus(s);
        s = idleStim();
        s.valid = 1'b1; s.mw = 1'b1; s.rw = 1'b1; s.rd = 5'd3; s.res = 32'h55;
        applyStimulus(s);

        s = idleStim();
        s.valid = 1'b1; s.rw = 1'b1; s.rd = 5'd0; s.res = 32'h66;
        applyStimulus(s);
        s.rd = 5'd7;
        applyStimulus(s);

        s = idleStim();
        s.valid = 1'b1; s.bt = 3'd7; s.tgt = 32'h0000_0600;
        applyStimulus(s);
        #2 rst_n = 1'b0;
        #1 checkResetState("midreset");
        cur = '0;
        shadowModel = 0;
        sbQueue.delete();
        @(negedge clk);
        rst_n = 1'b1;
        s = idleStim();
        s.valid = 1'b1; s.mw = 1'b1; s.mr = 1'b1; s.res = 32'h77; s.rd = 5'd9;
        applyStimulus(s);

        for (int k = 0; k < 60; k++) begin
            s = idleStim();
            s.valid = 1'($urandom_range(0, 3) != 0);
            s.res   = $urandom;
            s.sd    = $urandom;
            s.rd    = 5'($urandom_range(0, 31));
            s.c     = 1'($urandom_range(0, 1));
            s.z     = 1'($urandom_range(0, 1));
            s.n     = 1'($urandom_range(0, 1));
            s.v     = 1'($urandom_range(0, 1));
            s.rw    = 1'($urandom_range(0, 1));
            s.mr    = 1'($urandom_range(0, 1));
            s.mw    = 1'($urandom_range(0, 1));
            s.bt    = 3'($urandom_range(0, 7));
            s.tgt   = $urandom;
            s.stall = 1'($urandom_range(0, 5) == 0);
            s.flush = 1'($urandom_range(0, 5) == 0);
            applyStimulus(s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
